// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// downstream reset. Retries on lock timeout and parks in FAIL once retries are spent.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam int MAX_AB  = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                           LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_AB > RST_PULSE_CYCLES) ? MAX_AB : RST_PULSE_CYCLES;
  // The counter only ever needs to reach CNT_MAX-1, so it never wraps.
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_q;
  logic          locked_s;

  assign locked_s    = sync_q[1];
  assign debug_state = state;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 4'd0;
    end else if (restart) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == PULSE_LAST) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_cnt == RETRY_LIMIT) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state   <= S_PLL_RST;
              pll_rst <= 1'b1;
              if (retry_cnt != 4'hf) begin
                retry_cnt <= retry_cnt + 4'd1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          // A drop on the completing cycle still wins: the lock is not trusted.
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= S_RUN;
            cnt       <= '0;
            sys_rst   <= 1'b0;
            ready     <= 1'b1;
            retry_cnt <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
          end
        end

        S_FAIL: begin
          cnt <= '0;
        end

        default: begin
          state   <= S_PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed scenarios plus random lock/restart/reset traffic,
// all checked cycle by cycle against a phase/time-remaining reference model.
module tb_pll_reset_ctrl;

  localparam int RPC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MR  = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] debug_state;

  int n_checks = 0;
  int n_errors = 0;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (RPC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .debug_state(debug_state)
  );

  // ---------------- clock ----------------
  always #5 refclk = ~refclk;

  // ---------------- reference model ----------------
  // Phase plus cycles remaining in that phase; locked reaches decisions two samples late.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_RUN = 3, PH_DEAD = 4;
  int   ph;
  int   left;
  int   retries;
  logic lost;
  logic hist[$];
  logic [8:0] exp_q[$];

  task automatic model_reset();
    ph = PH_PULSE; left = RPC; retries = 0; lost = 1'b0;
    hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_edge(input logic l, input logic r);
    logic seen;
    logic [3:0] rv;
    seen = hist[0];
    void'(hist.pop_front());
    hist.push_back(l);
    if (r) begin
      ph = PH_PULSE; left = RPC; retries = 0; lost = 1'b0;
    end else if (ph == PH_PULSE) begin
      left--;
      if (left == 0) begin ph = PH_WAIT; left = LTC; end
    end else if (ph == PH_WAIT) begin
      if (seen) begin
        ph = PH_SETTLE; left = LSC;
      end else begin
        left--;
        if (left == 0) begin
          if (retries == MR) ph = PH_DEAD;
          else begin
            ph = PH_PULSE; left = RPC;
            retries = (retries + 1 > 15) ? 15 : retries + 1;
          end
        end
      end
    end else if (ph == PH_SETTLE) begin
      if (!seen) begin
        ph = PH_WAIT; left = LTC;
      end else begin
        left--;
        if (left == 0) begin ph = PH_RUN; retries = 0; end
      end
    end else if (ph == PH_RUN) begin
      if (!seen) begin ph = PH_PULSE; left = RPC; lost = 1'b1; end
    end
    rv = 4'(retries);
    exp_q.push_back({ph == PH_PULSE, ph != PH_RUN, ph == PH_RUN, ph == PH_DEAD, lost, rv});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input logic l, input logic r);
    logic [8:0] e;
    @(negedge refclk);
    locked  = l;
    restart = r;
    model_edge(l, r);
    @(posedge refclk);
    #1;
    e = exp_q.pop_front();
    check("pll_rst",   {3'b000, pll_rst},   {3'b000, e[8]});
    check("sys_rst",   {3'b000, sys_rst},   {3'b000, e[7]});
    check("ready",     {3'b000, ready},     {3'b000, e[6]});
    check("fail",      {3'b000, fail},      {3'b000, e[5]});
    check("lock_lost", {3'b000, lock_lost}, {3'b000, e[4]});
    check("retry_cnt", retry_cnt,           e[3:0]);
  endtask

  // Asserts rst between edges, checks outputs before any edge, releases between edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pll_rst",   {3'b000, pll_rst},   4'd1);
    check("rst_sys_rst",   {3'b000, sys_rst},   4'd1);
    check("rst_ready",     {3'b000, ready},     4'd0);
    check("rst_fail",      {3'b000, fail},      4'd0);
    check("rst_lock_lost", {3'b000, lock_lost}, 4'd0);
    check("rst_retry_cnt", retry_cnt,           4'd0);
    restart = 1'b0;
    @(posedge refclk);
    @(posedge refclk);
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int n;
    int pulses;
    int seg;
    logic prev;
    logic lv;
    rst = 1'b0; locked = 1'b0; restart = 1'b0;
    #1;

    // Power-on reset, then lock rises 3 cycles after pll_rst falls.
    do_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin tick(1'b0, 1'b0); n++; end
    check("pulse_len", 4'(n), 4'(RPC));
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
    n = 0;
    do begin tick(1'b1, 1'b0); n++; end while (ready !== 1'b1 && n < 40);
    check("lock_to_ready", 4'(n), 4'(2 + LSC + 1));

    // Lock drop in RUN for one cycle.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n = 1;
    while (sys_rst !== 1'b1 && n < 10) begin tick(1'b1, 1'b0); n++; end
    check("drop_to_sys_rst", 4'(n), 4'd3);
    check("drop_lock_lost", {3'b000, lock_lost}, 4'd1);
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin tick(1'b1, 1'b0); n++; end
    check("repulse_len", 4'(n), 4'(RPC));
    n = 0;
    while (ready !== 1'b1 && n < 40) begin tick(1'b1, 1'b0); n++; end
    check("rerun_ready", {3'b000, ready}, 4'd1);
    check("sticky_lock_lost", {3'b000, lock_lost}, 4'd1);

    // Glitch while STABLE has counted 5 locked cycles.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n = 0;
    do begin tick(1'b1, 1'b0); n++; end while (ready !== 1'b1 && n < 40);
    check("glitch_to_ready", 4'(n), 4'd11);

    // Lock never arrives: three pulses then FAIL, held indefinitely.
    locked = 1'b0;
    do_reset();
    pulses = 1; prev = 1'b1;
    for (int i = 0; i < 160; i++) begin
      tick(1'b0, 1'b0);
      if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
      prev = pll_rst;
    end
    check("timeout_pulses", 4'(pulses), 4'(MR + 1));
    check("timeout_fail", {3'b000, fail}, 4'd1);
    for (int i = 0; i < 20; i++) tick(1'($urandom_range(0, 1)), 1'b0);
    check("fail_held", {3'b000, fail}, 4'd1);

    // Restart out of FAIL with lock present.
    tick(1'b1, 1'b1);
    check("restart_fail", {3'b000, fail}, 4'd0);
    check("restart_pll_rst", {3'b000, pll_rst}, 4'd1);
    check("restart_retry", retry_cnt, 4'd0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin tick(1'b1, 1'b0); n++; end
    check("restart_to_ready", 4'(n), 4'(RPC + 1 + LSC));

    // Asynchronous reset mid-STABLE and mid-RUN.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    check("pre_reset_run", {3'b000, ready}, 4'd1);
    do_reset();

    // Random lock behaviour with occasional restart and reset.
    lv = 1'b1; seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lv  = ($urandom_range(0, 2) != 0);
        seg = lv ? $urandom_range(1, 60) : $urandom_range(1, 110);
      end
      seg--;
      if ($urandom_range(0, 599) == 0) do_reset();
      tick(lv, ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
